writeback_queue: RTL

- Write-side counterpart of the decode/register-read stage. Accepts completed instructions from execute/memory and drives the register-file write port.
- Holds results in an in-order queue until each one is writable. Loads wait for data-memory response data.
- Publishes a busy mask so decode can stall on pending destination registers.

---
 rtl/writeback_queue_pkg.sv | 37 +++
 rtl/writeback_queue_load_data_format.sv | 32 +++
 rtl/writeback_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_pkg.sv
// -----------------------------------------------------------------------------
// writeback_queue_pkg
//   Shared constants for the writeback queue: datapath width, the LEGv8 load
//   opcodes whose data needs formatting, the zero-register index, and a helper
//   that classifies a load opcode into the extension it needs.
// -----------------------------------------------------------------------------
package writeback_queue_pkg;

   localparam int          WORD_W    = 64;

   localparam logic [10:0] OP_LDUR   = 11'h7C2;
   localparam logic [10:0] OP_LDURB  = 11'h1C2;
   localparam logic [10:0] OP_LDURH  = 11'h3C2;
   localparam logic [10:0] OP_LDURSW = 11'h5C4;

   localparam logic [4:0]  XZR_REG   = 5'd31;

   typedef enum logic [1:0] {
      FMT_FULL = 2'd0,
      FMT_ZX8  = 2'd1,
      FMT_ZX16 = 2'd2,
      FMT_SX32 = 2'd3
   } load_fmt_e;

   // Unknown load opcodes fall back to the full word.
   function automatic load_fmt_e decode_load_fmt(input logic [10:0] op);
      load_fmt_e fmt;
      case (op)
         OP_LDURB:  fmt = FMT_ZX8;
         OP_LDURH:  fmt = FMT_ZX16;
         OP_LDURSW: fmt = FMT_SX32;
         default:   fmt = FMT_FULL;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/writeback_queue_load_data_format.sv
// -----------------------------------------------------------------------------
// load_data_format
//   Combinational formatter for raw data-memory load data.
//   Ports:
//     i_opcode : 11-bit LEGv8 opcode of the load
//     i_raw    : raw WORD-wide data from data memory
//     o_data   : zero/sign-extended or full-word result
// -----------------------------------------------------------------------------
module load_data_format
   import writeback_queue_pkg::*;
#(
   parameter int WORD = WORD_W
) (
   input  logic [10:0]     i_opcode,
   input  logic [WORD-1:0] i_raw,
   output logic [WORD-1:0] o_data
);

   load_fmt_e w_fmt;

   always_comb begin
      w_fmt  = decode_load_fmt(i_opcode);
      o_data = i_raw;
      case (w_fmt)
         FMT_ZX8:  o_data = {{(WORD-8){1'b0}},  i_raw[7:0]};
         FMT_ZX16: o_data = {{(WORD-16){1'b0}}, i_raw[15:0]};
         FMT_SX32: o_data = {{(WORD-32){i_raw[31]}}, i_raw[31:0]};
         default:  o_data = i_raw;
      endcase
   end

endmodule

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//   In-order queue between execute/memory and the register-file write port.
//   Completed instructions are enqueued; loads wait for their data-memory
//   response; the head entry retires (one per cycle) once it has data.
//   Ports:
//     write_clk, reset_n          : clock, synchronous active-low reset
//     wb_valid / wb_ready         : accept handshake from execute
//     wb_rd, wb_reg_write,
//     wb_mem_to_reg, wb_opcode,
//     wb_alu_result               : instruction payload
//     mem_rsp_valid, mem_rsp_data : in-order load responses
//     rf_write_en/reg/data        : registered register-file write port
//     busy_mask                   : destinations of all pending entries
//     rsp_error                   : sticky, response with no waiting load
// -----------------------------------------------------------------------------
module writeback_queue
   import writeback_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WORD  = WORD_W
) (
   input  logic            write_clk,
   input  logic            reset_n,
   input  logic            wb_valid,
   output logic            wb_ready,
   input  logic [4:0]      wb_rd,
   input  logic            wb_reg_write,
   input  logic            wb_mem_to_reg,
   input  logic [10:0]     wb_opcode,
   input  logic [WORD-1:0] wb_alu_result,
   input  logic            mem_rsp_valid,
   input  logic [WORD-1:0] mem_rsp_data,
   output logic            rf_write_en,
   output logic [4:0]      rf_write_reg,
   output logic [WORD-1:0] rf_write_data,
   output logic [31:0]     busy_mask,
   output logic            rsp_error
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Entry storage (payload is not reset; r_valid qualifies it)
   logic [4:0]      r_rd   [DEPTH];
   logic            r_m2r  [DEPTH];
   logic [10:0]     r_op   [DEPTH];
   logic [WORD-1:0] r_data [DEPTH];
   logic            r_has  [DEPTH];
   logic [DEPTH-1:0] r_valid;

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic            r_rf_write_en;
   logic [4:0]      r_rf_write_reg;
   logic [WORD-1:0] r_rf_write_data;
   logic            r_rsp_error;

   logic             w_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_rsp_found;
   logic             w_rsp_fill;
   logic [PTR_W-1:0] w_rsp_ptr;
   logic [PTR_W-1:0] w_scan_idx;
   logic [WORD-1:0]  w_fmt_data;
   logic [31:0]      w_busy;

   // Acceptance looks at the count before this edge's retire.
   assign w_ready = reset_n && (r_count < CNT_W'(DEPTH));
   assign w_push  = wb_valid && w_ready && wb_reg_write;
   assign w_pop   = r_valid[r_head] && r_has[r_head];

   // Oldest load still waiting for data, scanning from the head. Only state
   // registered before this edge is visible, so a load accepted on the same
   // edge as a response can never be its target.
   always_comb begin
      w_rsp_found = 1'b0;
      w_rsp_ptr   = r_head;
      w_scan_idx  = r_head;
      for (int i = 0; i < DEPTH; i++) begin
         w_scan_idx = r_head + PTR_W'(i);
         if (!w_rsp_found && r_valid[w_scan_idx] && r_m2r[w_scan_idx] &&
             !r_has[w_scan_idx]) begin
            w_rsp_found = 1'b1;
            w_rsp_ptr   = w_scan_idx;
         end
      end
   end

   assign w_rsp_fill = reset_n && mem_rsp_valid && w_rsp_found;

   load_data_format #(
      .WORD (WORD)
   ) u_fmt (
      .i_opcode (r_op[w_rsp_ptr]),
      .i_raw    (mem_rsp_data),
      .o_data   (w_fmt_data)
   );

   // Pending destinations; XZR never stalls decode.
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i]) begin
            w_busy[r_rd[i]] = 1'b1;
         end
      end
      w_busy[XZR_REG] = 1'b0;
   end

   // Payload storage: written on enqueue and on load response. Push and fill
   // never address the same slot (fill targets an already valid entry).
   always_ff @(posedge write_clk) begin
      if (w_push) begin
         r_rd[r_tail]   <= wb_rd;
         r_m2r[r_tail]  <= wb_mem_to_reg;
         r_op[r_tail]   <= wb_opcode;
         r_data[r_tail] <= wb_alu_result;
         r_has[r_tail]  <= !wb_mem_to_reg;
      end
      if (w_rsp_fill) begin
         r_data[w_rsp_ptr] <= w_fmt_data;
         r_has[w_rsp_ptr]  <= 1'b1;
      end
   end

   // Control: pointers, occupancy, retire port and error flag.
   always_ff @(posedge write_clk) begin
      if (!reset_n) begin
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_valid         <= '0;
         r_rf_write_en   <= 1'b0;
         r_rf_write_reg  <= '0;
         r_rf_write_data <= '0;
         r_rsp_error     <= 1'b0;
      end else begin
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
            r_rf_write_en   <= (r_rd[r_head] != XZR_REG);
            r_rf_write_reg  <= r_rd[r_head];
            r_rf_write_data <= r_data[r_head];
         end else begin
            r_rf_write_en   <= 1'b0;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         if (mem_rsp_valid && !w_rsp_found) begin
            r_rsp_error <= 1'b1;
         end
      end
   end

   assign wb_ready      = w_ready;
   assign busy_mask     = reset_n ? w_busy : 32'd0;
   assign rf_write_en   = r_rf_write_en;
   assign rf_write_reg  = r_rf_write_reg;
   assign rf_write_data = r_rf_write_data;
   assign rsp_error     = r_rsp_error;

endmodule
